// File: rtl/sram_access_arbiter.sv
// SRAM sequencer sharing four 64 KB blocks between the 68k bus and a DMA port.
// Define SRAM_DMA_BURST_EN to let up to four DMA accesses run back to back.
module sram_access_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              Clock,
    input  logic              Reset_L,
    input  logic [ADDR_W-1:0] Address,
    input  logic              SRamSelect_H,
    input  logic              AS_L,
    input  logic              UDS_L,
    input  logic              LDS_L,
    input  logic              RW_H,
    input  logic              DmaReq_H,
    input  logic [ADDR_W-1:0] DmaAddress,
    input  logic              DmaRW_H,
    input  logic [1:0]        DmaByteEn_H,
    output logic              DmaGrant_H,
    output logic              DmaAck_H,
    output logic [ADDR_W-3:0] SRamAddress,
    output logic              Block0_H,
    output logic              Block1_H,
    output logic              Block2_H,
    output logic              Block3_H,
    output logic              SRam_OE_L,
    output logic              SRam_WE_L,
    output logic              SRam_UB_L,
    output logic              SRam_LB_L,
    output logic              Dtack_L
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_DONE,
        DMA_ACC,
        DMA_DONE
    } state_t;

    localparam int         AW      = ADDR_W - 2;
    localparam int         DW      = 4 + AW + 4;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    state_t        state;
    state_t        state_n;
    logic [3:0]    cnt;
    logic [3:0]    cnt_n;
    logic          last_dma;
    logic          last_dma_n;
    logic [3:0]    blk;
    logic [3:0]    blk_n;
    logic [AW-1:0] addr_n;
    logic          oe_n;
    logic          we_n;
    logic          ub_n;
    logic          lb_n;
    logic          dtack_n;
    logic          ack_n;
    logic          grant_n;

`ifdef SRAM_DMA_BURST_EN
    logic [2:0]    burst;
    logic [2:0]    burst_n;
`endif

    logic          cpu_req;
    logic          dma_req;
    logic [3:0]    cpu_blk;
    logic [3:0]    dma_blk;
    logic [DW-1:0] cpu_drive;
    logic [DW-1:0] dma_drive;
    logic [DW-1:0] hold_drive;

    assign cpu_req = SRamSelect_H & ~AS_L & (~UDS_L | ~LDS_L);
    assign dma_req = DmaReq_H & (|DmaByteEn_H);

    assign cpu_blk = 4'b0001 << Address[ADDR_W-1:ADDR_W-2];
    assign dma_blk = 4'b0001 << DmaAddress[ADDR_W-1:ADDR_W-2];

    // strobe bundle: {blocks, address, oe, we, ub, lb}, all active-low strobes
    assign cpu_drive = {
        cpu_blk, Address[AW-1:0],
        ~RW_H, RW_H, UDS_L, LDS_L
    };
    assign dma_drive = {
        dma_blk, DmaAddress[AW-1:0],
        ~DmaRW_H, DmaRW_H,
        ~DmaByteEn_H[1], ~DmaByteEn_H[0]
    };
    assign hold_drive = {
        blk, SRamAddress,
        SRam_OE_L, 1'b1, SRam_UB_L, SRam_LB_L
    };

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_dma_n = last_dma;
        blk_n      = '0;
        addr_n     = '0;
        oe_n       = 1'b1;
        we_n       = 1'b1;
        ub_n       = 1'b1;
        lb_n       = 1'b1;
        dtack_n    = 1'b1;
        ack_n      = 1'b0;
        grant_n    = 1'b0;
`ifdef SRAM_DMA_BURST_EN
        burst_n    = burst;
`endif
        unique case (state)
            IDLE: begin
`ifdef SRAM_DMA_BURST_EN
                burst_n = '0;
`endif
                if (cpu_req && (!dma_req || last_dma)) begin
                    state_n    = CPU_ACC;
                    cnt_n      = WS_LOAD;
                    last_dma_n = 1'b0;
                    {blk_n, addr_n, oe_n, we_n, ub_n, lb_n} = cpu_drive;
                end else if (dma_req) begin
                    state_n    = DMA_ACC;
                    cnt_n      = WS_LOAD;
                    last_dma_n = 1'b1;
                    grant_n    = 1'b1;
                    {blk_n, addr_n, oe_n, we_n, ub_n, lb_n} = dma_drive;
                end
            end
            CPU_ACC: begin
                // losing AS mid-access abandons the cycle without DTACK
                if (AS_L) begin
                    state_n = IDLE;
                end else if (cnt == 4'd0) begin
                    state_n = CPU_DONE;
                    dtack_n = 1'b0;
                    {blk_n, addr_n, oe_n, we_n, ub_n, lb_n} = hold_drive;
                end else begin
                    cnt_n = cnt - 4'd1;
                    {blk_n, addr_n, oe_n, we_n, ub_n, lb_n} = cpu_drive;
                end
            end
            CPU_DONE: begin
                if (AS_L) begin
                    state_n = IDLE;
                end else begin
                    dtack_n = 1'b0;
                    {blk_n, addr_n, oe_n, we_n, ub_n, lb_n} = hold_drive;
                end
            end
            DMA_ACC: begin
                grant_n = 1'b1;
                if (cnt == 4'd0) begin
                    state_n = DMA_DONE;
                    ack_n   = 1'b1;
                    {blk_n, addr_n, oe_n, we_n, ub_n, lb_n} = hold_drive;
                end else begin
                    cnt_n = cnt - 4'd1;
                    {blk_n, addr_n, oe_n, we_n, ub_n, lb_n} = dma_drive;
                end
            end
            DMA_DONE: begin
                state_n = IDLE;
`ifdef SRAM_DMA_BURST_EN
                burst_n = burst + 3'd1;
                // burst holds the completions before this one
                if (dma_req && !cpu_req && burst < 3'd3) begin
                    state_n = DMA_ACC;
                    cnt_n   = WS_LOAD;
                    grant_n = 1'b1;
                    {blk_n, addr_n, oe_n, we_n, ub_n, lb_n} = dma_drive;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state       <= IDLE;
            cnt         <= '0;
            last_dma    <= 1'b1;
            blk         <= '0;
            SRamAddress <= '0;
            SRam_OE_L   <= 1'b1;
            SRam_WE_L   <= 1'b1;
            SRam_UB_L   <= 1'b1;
            SRam_LB_L   <= 1'b1;
            Dtack_L     <= 1'b1;
            DmaAck_H    <= 1'b0;
            DmaGrant_H  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_dma    <= last_dma_n;
            blk         <= blk_n;
            SRamAddress <= addr_n;
            SRam_OE_L   <= oe_n;
            SRam_WE_L   <= we_n;
            SRam_UB_L   <= ub_n;
            SRam_LB_L   <= lb_n;
            Dtack_L     <= dtack_n;
            DmaAck_H    <= ack_n;
            DmaGrant_H  <= grant_n;
        end
    end

`ifdef SRAM_DMA_BURST_EN
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            burst <= '0;
        end else begin
            burst <= burst_n;
        end
    end
`endif

    assign Block0_H = blk[0];
    assign Block1_H = blk[1];
    assign Block2_H = blk[2];
    assign Block3_H = blk[3];

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomized bench for sram_access_arbiter against a transaction-level model.
// Expected strobes come from per-access phase rules, not from the FSM encoding.
module tb_sram_access_arbiter;

    localparam int WS = 1;
`ifdef SRAM_DMA_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset_L = 1'b0;
    logic [16:0] Address = '0;
    logic        SRamSelect_H = 1'b0;
    logic        AS_L = 1'b1;
    logic        UDS_L = 1'b1;
    logic        LDS_L = 1'b1;
    logic        RW_H = 1'b1;
    logic        DmaReq_H = 1'b0;
    logic [16:0] DmaAddress = '0;
    logic        DmaRW_H = 1'b1;
    logic [1:0]  DmaByteEn_H = '0;
    logic        DmaGrant_H;
    logic        DmaAck_H;
    logic [14:0] SRamAddress;
    logic        Block0_H;
    logic        Block1_H;
    logic        Block2_H;
    logic        Block3_H;
    logic        SRam_OE_L;
    logic        SRam_WE_L;
    logic        SRam_UB_L;
    logic        SRam_LB_L;
    logic        Dtack_L;

    int n_checks = 0;
    int n_errors = 0;
    bit last_dma;

    sram_access_arbiter #(
        .WAIT_STATES(WS),
        .ADDR_W     (17)
    ) dut (
        .Clock       (Clock),
        .Reset_L     (Reset_L),
        .Address     (Address),
        .SRamSelect_H(SRamSelect_H),
        .AS_L        (AS_L),
        .UDS_L       (UDS_L),
        .LDS_L       (LDS_L),
        .RW_H        (RW_H),
        .DmaReq_H    (DmaReq_H),
        .DmaAddress  (DmaAddress),
        .DmaRW_H     (DmaRW_H),
        .DmaByteEn_H (DmaByteEn_H),
        .DmaGrant_H  (DmaGrant_H),
        .DmaAck_H    (DmaAck_H),
        .SRamAddress (SRamAddress),
        .Block0_H    (Block0_H),
        .Block1_H    (Block1_H),
        .Block2_H    (Block2_H),
        .Block3_H    (Block3_H),
        .SRam_OE_L   (SRam_OE_L),
        .SRam_WE_L   (SRam_WE_L),
        .SRam_UB_L   (SRam_UB_L),
        .SRam_LB_L   (SRam_LB_L),
        .Dtack_L     (Dtack_L)
    );

    always #5 Clock = ~Clock;

    logic [10:0] obs;
    assign obs = {
        DmaGrant_H, DmaAck_H,
        Block3_H, Block2_H, Block1_H, Block0_H,
        SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L,
        Dtack_L
    };

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ph: 0 idle, 1 strobes active, 2 completion cycle
    function automatic logic [10:0] exp_bus(input int ph, input bit dma,
                                            input logic [16:0] a,
                                            input logic rw, input logic u,
                                            input logic l);
        logic [3:0] blk;
        logic       ack;
        logic       dtack;
        logic       we;
        if (ph == 0) return {2'b00, 4'b0000, 5'b11111};
        blk   = 4'(1 << (a / 17'd32768));
        ack   = (ph == 2) && dma;
        dtack = !((ph == 2) && !dma);
        we    = (ph == 1) ? rw : 1'b1;
        return {dma, ack, blk, !rw, we, u, l, dtack};
    endfunction

    task automatic chk_bus(input string tag, input int ph, input bit dma,
                           input logic [16:0] a, input logic rw,
                           input logic u, input logic l);
        logic [31:0] ea;
        ea = (ph == 0) ? 32'd0 : 32'(a % 17'd32768);
        check({tag, "_bus"}, 32'(obs), 32'(exp_bus(ph, dma, a, rw, u, l)));
        check({tag, "_addr"}, 32'(SRamAddress), ea);
    endtask

    task automatic chk_idle(input string tag);
        chk_bus(tag, 0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic cpu_set(input logic [16:0] a, input logic rw,
                           input logic u, input logic l);
        Address = a;
        RW_H = rw;
        UDS_L = u;
        LDS_L = l;
        AS_L = 1'b0;
        SRamSelect_H = 1'b1;
    endtask

    task automatic cpu_clear();
        AS_L = 1'b1;
        UDS_L = 1'b1;
        LDS_L = 1'b1;
        SRamSelect_H = 1'b0;
    endtask

    task automatic dma_set(input logic [16:0] a, input logic rw,
                           input logic [1:0] be);
        DmaAddress = a;
        DmaRW_H = rw;
        DmaByteEn_H = be;
        DmaReq_H = 1'b1;
    endtask

    task automatic dma_clear();
        DmaReq_H = 1'b0;
        DmaByteEn_H = 2'b00;
    endtask

    // WS+1 strobe cycles, then the completion cycle; ends on its negedge
    task automatic acc_phase(input string tag, input bit dma,
                             input logic [16:0] a, input logic rw,
                             input logic u, input logic l);
        for (int k = 0; k <= WS; k++) begin
            @(negedge Clock);
            chk_bus({tag, "_acc"}, 1, dma, a, rw, u, l);
        end
        @(negedge Clock);
        chk_bus({tag, "_done"}, 2, dma, a, rw, u, l);
    endtask

    task automatic cpu_xfer(input logic [16:0] a, input logic rw,
                            input logic u, input logic l, input bit junk);
        if (junk) dma_set(17'h0, 1'b1, 2'b00);
        cpu_set(a, rw, u, l);
        acc_phase("cpu", 1'b0, a, rw, u, l);
        @(negedge Clock);
        chk_bus("cpu_hold", 2, 1'b0, a, rw, u, l);
        cpu_clear();
        @(negedge Clock);
        chk_idle("cpu_end");
        if (junk) dma_clear();
        last_dma = 1'b0;
    endtask

    task automatic dma_xfer(input logic [16:0] a, input logic rw,
                            input logic [1:0] be);
        dma_set(a, rw, be);
        acc_phase("dma", 1'b1, a, rw, !be[1], !be[0]);
        dma_clear();
        @(negedge Clock);
        chk_idle("dma_end");
        last_dma = 1'b1;
    endtask

    task automatic both_xfer(input logic [16:0] ca, input logic crw,
                             input logic u, input logic l,
                             input logic [16:0] da, input logic drw,
                             input logic [1:0] be);
        cpu_set(ca, crw, u, l);
        dma_set(da, drw, be);
        if (last_dma) begin
            acc_phase("rr_cpu1", 1'b0, ca, crw, u, l);
            cpu_clear();
            @(negedge Clock);
            chk_idle("rr_gap");
            acc_phase("rr_dma2", 1'b1, da, drw, !be[1], !be[0]);
            dma_clear();
            @(negedge Clock);
            chk_idle("rr_end");
            last_dma = 1'b1;
        end else begin
            acc_phase("rr_dma1", 1'b1, da, drw, !be[1], !be[0]);
            dma_clear();
            @(negedge Clock);
            chk_idle("rr_gap");
            acc_phase("rr_cpu2", 1'b0, ca, crw, u, l);
            cpu_clear();
            @(negedge Clock);
            chk_idle("rr_end");
            last_dma = 1'b0;
        end
    endtask

    initial begin
        logic [16:0] ca;
        logic [16:0] da;
        logic [1:0]  cv;
        logic [1:0]  be;
        #12;
        chk_idle("reset");
        @(negedge Clock);
        Reset_L = 1'b1;
        last_dma = 1'b1;
        @(negedge Clock);
        chk_idle("post_reset");

        both_xfer(17'h0A002, 1'b0, 1'b0, 1'b1, 17'h13456, 1'b1, 2'b11);
        cpu_xfer(17'h1FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        cpu_xfer(17'h0A002, 1'b0, 1'b0, 1'b1, 1'b1);
        both_xfer(17'h04444, 1'b1, 1'b1, 1'b0, 17'h08001, 1'b0, 2'b01);

        cpu_set(17'h0A002, 1'b0, 1'b0, 1'b1);
        @(negedge Clock);
        chk_bus("rst_pre", 1, 1'b0, 17'h0A002, 1'b0, 1'b0, 1'b1);
        Reset_L = 1'b0;
        #1;
        chk_idle("rst_mid");
        @(negedge Clock);
        cpu_clear();
        Reset_L = 1'b1;
        last_dma = 1'b1;
        @(negedge Clock);
        chk_idle("rst_after");

        dma_set(17'h16000, 1'b1, 2'b10);
        for (int i = 0; i < 6; i++) begin
            if (i > 0 && (!BURST || i == 4)) begin
                @(negedge Clock);
                chk_idle("burst_gap");
            end
            acc_phase("burst", 1'b1, 17'h16000, 1'b1, 1'b0, 1'b1);
        end
        dma_clear();
        @(negedge Clock);
        chk_idle("burst_end");
        last_dma = 1'b1;

        for (int n = 0; n < 40; n++) begin
            ca = 17'($urandom);
            da = 17'($urandom);
            cv = 2'($urandom_range(1, 3));
            be = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 2))
                0: cpu_xfer(ca, 1'($urandom), !cv[1], !cv[0],
                            1'($urandom));
                1: dma_xfer(da, 1'($urandom), be);
                default: both_xfer(ca, 1'($urandom), !cv[1], !cv[0],
                                   da, 1'($urandom), be);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
